// File: rtl/mio_uart_pkg.sv
// mio_uart_pkg: shared types and constants for the memory-mapped UART
// transmitter.
//   uart_st_t          - transmit FSM state encoding
//   STAT_*_BIT         - bit positions inside the 32-bit status word
//   WDATA_CLR_OVF_BIT  - write-data bit that selects the clear-overflow command
//   even_parity8()     - even parity of one data byte
package mio_uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_st_t;

   localparam int STAT_PARITY_BIT   = 12;
   localparam int STAT_OVF_BIT      = 11;
   localparam int STAT_FULL_BIT     = 10;
   localparam int STAT_EMPTY_BIT    = 9;
   localparam int STAT_BUSY_BIT     = 8;
   localparam int WDATA_CLR_OVF_BIT = 8;

   function automatic logic even_parity8(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/mio_uart_fifo.sv
// mio_uart_fifo: synchronous FIFO feeding the UART transmitter.
//   clk, rst  - clock and synchronous active-high reset
//   push, din - write request and data; ignored when full unless pop is
//               also accepted in the same cycle
//   pop, dout - read request and head-of-queue data (dout valid when !empty)
//   full      - registered, high when 2^DEPTH_LOG2 entries are held
//   empty     - registered, high when no entry is held
//   count     - registered occupancy, 0..2^DEPTH_LOG2
module mio_uart_fifo
   import mio_uart_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic [WIDTH-1:0]      din,
   output logic [WIDTH-1:0]      dout,
   output logic                  full,
   output logic                  empty,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CNT_W = DEPTH_LOG2 + 1;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [WIDTH-1:0]      mem_d [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  push_ok_s;
   logic                  pop_ok_s;

   // Qualify requests and compute next pointers, occupancy and flags.
   always_comb begin
      pop_ok_s  = pop && !empty_q;
      // A full FIFO still takes a write when the head leaves in the same cycle.
      push_ok_s = push && (!full_q || pop_ok_s);
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1'b1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1'b1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_W'(1'b1);
         2'b01:   count_d = count_q - CNT_W'(1'b1);
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CNT_W'(DEPTH));
      empty_d = (count_d == CNT_W'(1'b0));
   end

   // Storage, pointers and registered flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q <= {DEPTH_LOG2{1'b0}};
         rd_ptr_q <= {DEPTH_LOG2{1'b0}};
         count_q  <= {CNT_W{1'b0}};
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = full_q;
   assign empty = empty_q;
   assign count = count_q;

endmodule

// File: rtl/mio_uart_tx.sv
// mio_uart_tx: memory-mapped UART transmitter (8N1, or 8E1 when the
// MIO_UART_TX_PARITY_EN macro is defined).
//   clk, rst  - clock and synchronous active-high reset
//   we, wdata - bus write; wdata[8]=1 clears the overflow flag, otherwise
//               wdata[7:0] is queued for transmission
//   txd       - registered serial line, idle high
//   busy      - registered, frame on the line or bytes still queued
//   fifo_full - registered FIFO full flag
//   status    - {19'b0, parity_en, ovf, full, empty, busy, count[7:0]},
//               built only from registers
module mio_uart_tx
   import mio_uart_pkg::*;
#(
   parameter int DIV        = 868,
   parameter int DEPTH_LOG2 = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [31:0] wdata,
   output logic        txd,
   output logic        busy,
   output logic        fifo_full,
   output logic [31:0] status
);

`ifdef MIO_UART_TX_PARITY_EN
   localparam logic PARITY_FLAG = 1'b1;
`else
   localparam logic PARITY_FLAG = 1'b0;
`endif

   uart_st_t              state_q, state_d;
   logic [15:0]           baud_q, baud_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [7:0]            shreg_q, shreg_d;
   logic                  txd_q, txd_d;
   logic                  busy_q, busy_d;
   logic                  ovf_q, ovf_d;
`ifdef MIO_UART_TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   logic                  clr_cmd_s, push_req_s, push_ok_s, pop_s, baud_end_s;
   logic [7:0]            fifo_dout_s;
   logic                  fifo_full_s, fifo_empty_s;
   logic [DEPTH_LOG2:0]   fifo_count_s;
   logic                  wdata_unused;

   assign wdata_unused = ^wdata[31:9];

   mio_uart_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_ok_s),
      .pop   (pop_s),
      .din   (wdata[7:0]),
      .dout  (fifo_dout_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s),
      .count (fifo_count_s)
   );

   // Write decode, push acceptance and the sticky overflow flag.
   always_comb begin
      clr_cmd_s  = we && wdata[WDATA_CLR_OVF_BIT];
      push_req_s = we && !wdata[WDATA_CLR_OVF_BIT];
      push_ok_s  = push_req_s && (!fifo_full_s || pop_s);
      if (clr_cmd_s) begin
         ovf_d = 1'b0;
      end else if (push_req_s && !push_ok_s) begin
         ovf_d = 1'b1;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Transmit FSM: next state, baud/bit counters and shift register.
   always_comb begin
      baud_end_s = (baud_q == 16'(DIV - 1));
      state_d    = state_q;
      baud_d     = baud_q + 16'd1;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      pop_s      = 1'b0;
`ifdef MIO_UART_TX_PARITY_EN
      par_d      = par_q;
`endif
      case (state_q)
         IDLE: begin
            baud_d = 16'd0;
            if (!fifo_empty_s) begin
               pop_s     = 1'b1;
               shreg_d   = fifo_dout_s;
               bit_cnt_d = 3'd0;
`ifdef MIO_UART_TX_PARITY_EN
               par_d     = even_parity8(fifo_dout_s);
`endif
               state_d   = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               state_d = DATA;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            if (baud_end_s) begin
               baud_d    = 16'd0;
               shreg_d   = {1'b0, shreg_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
`ifdef MIO_UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
`ifdef MIO_UART_TX_PARITY_EN
         PARITY: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               state_d = STOP;
            end else begin
               state_d = PARITY;
            end
         end
`endif
         STOP: begin
            if (baud_end_s) begin
               baud_d  = 16'd0;
               state_d = IDLE;
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            baud_d  = 16'd0;
            state_d = IDLE;
         end
      endcase
   end

   // Line level and busy for the next cycle, derived from the current state
   // so that both outputs come straight from flops.
   always_comb begin
      case (state_q)
         IDLE:    txd_d = 1'b1;
         START:   txd_d = 1'b0;
         DATA:    txd_d = shreg_q[0];
`ifdef MIO_UART_TX_PARITY_EN
         PARITY:  txd_d = par_q;
`endif
         STOP:    txd_d = 1'b1;
         default: txd_d = 1'b1;
      endcase
      busy_d = (state_q != IDLE) || !fifo_empty_s;
   end

   // State register; reset aborts any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         baud_q    <= 16'd0;
         bit_cnt_q <= 3'd0;
         shreg_q   <= 8'd0;
         txd_q     <= 1'b1;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
`ifdef MIO_UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
         shreg_q   <= shreg_d;
         txd_q     <= txd_d;
         busy_q    <= busy_d;
         ovf_q     <= ovf_d;
`ifdef MIO_UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   // Status word packing (all fields are register outputs).
   always_comb begin
      status                  = 32'd0;
      status[STAT_PARITY_BIT] = PARITY_FLAG;
      status[STAT_OVF_BIT]    = ovf_q;
      status[STAT_FULL_BIT]   = fifo_full_s;
      status[STAT_EMPTY_BIT]  = fifo_empty_s;
      status[STAT_BUSY_BIT]   = busy_q;
      status[7:0]             = 8'(fifo_count_s);
   end

   assign txd       = txd_q;
   assign busy      = busy_q;
   assign fifo_full = fifo_full_s;

endmodule

// File: tb/tb_mio_uart_tx.sv
// tb_mio_uart_tx: directed + randomized bench for mio_uart_tx with DIV=4,
// DEPTH_LOG2=2. Expected line bits come from a byte-level frame model
// (start, LSB-first data, optional even parity, stop) and a byte queue.
module tb_mio_uart_tx;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;
`ifdef MIO_UART_TX_PARITY_EN
   localparam int          FRAME_BITS = 11;
   localparam logic [31:0] STAT_RST   = 32'h0000_1200;
   localparam logic [31:0] PAR_FLAG   = 32'h0000_1000;
`else
   localparam int          FRAME_BITS = 10;
   localparam logic [31:0] STAT_RST   = 32'h0000_0200;
   localparam logic [31:0] PAR_FLAG   = 32'h0000_0000;
`endif
   localparam int FRAME_CYC = FRAME_BITS * DIV;

   logic        clk;
   logic        rst;
   logic        we;
   logic [31:0] wdata;
   logic        txd;
   logic        busy;
   logic        fifo_full;
   logic [31:0] status;

   int checks;
   int errors;
   int cyc;
   logic [7:0] model_q[$];

   mio_uart_tx #(.DIV(DIV), .DEPTH_LOG2(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .we        (we),
      .wdata     (wdata),
      .txd       (txd),
      .busy      (busy),
      .fifo_full (fifo_full),
      .status    (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Line level of bit slot k for a frame carrying byte b.
   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      if (k == 9 && FRAME_BITS == 11) return ^b;
      return 1'b1;
   endfunction

   // Follow one frame whose start bit reaches the line at cycle t0; checks
   // each bit at mid-slot and optionally writes ib on the cycle the next pop
   // happens. Returns at cycle t0+FRAME_CYC.
   task automatic run_frame(input int t0, input logic [7:0] b, input bit inj,
                            input logic [7:0] ib, input string tag);
      int e;
      while (cyc < t0 + FRAME_CYC) begin
         e = cyc - t0;
         if (e == 0) chk($sformatf("%s_start_edge", tag), {31'd0, txd}, 32'd0);
         if (e >= 0 && (e % DIV) == DIV / 2)
            chk($sformatf("%s_bit%0d", tag, e / DIV), {31'd0, txd}, {31'd0, frame_bit(b, e / DIV)});
         if (e == FRAME_CYC - 1) chk($sformatf("%s_busy_hold", tag), {31'd0, busy}, 32'd1);
         if (inj && e == FRAME_CYC - 1) begin
            we    = 1'b1;
            wdata = {24'd0, ib};
         end else begin
            we = 1'b0;
         end
         tick();
      end
      we = 1'b0;
      chk($sformatf("%s_line_end", tag), {31'd0, txd}, 32'd1);
   endtask

   initial begin
      logic [7:0] b;
      logic [7:0] ib;
      int t0;
      int f;
      bit high_ok;
      bit busy_ok;
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b1;
      we     = 1'b0;
      wdata  = 32'd0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_full", {31'd0, fifo_full}, 32'd0);
      chk("rst_status", status, STAT_RST);

      // Single byte 0xA5: line falls two edges after the write edge
      we = 1'b1; wdata = 32'h0000_00A5;
      tick();
      we = 1'b0;
      chk("a5_busy_rise", {31'd0, busy}, 32'd0);
      chk("a5_lat_n", {31'd0, txd}, 32'd1);
      tick();
      chk("a5_lat_n1", {31'd0, txd}, 32'd1);
      tick();
      chk("a5_lat_n2", {31'd0, txd}, 32'd0);
      t0 = cyc;
      run_frame(t0, 8'hA5, 1'b0, 8'h00, "a5");
      chk("a5_busy_drop", {31'd0, busy}, 32'd0);
      chk("a5_status_idle", status, STAT_RST);

      // Directed 0x07 (parity bit 1 when parity is built in)
      tick();
      we = 1'b1; wdata = 32'h0000_0007;
      tick();
      we = 1'b0;
      t0 = cyc + 2;
      run_frame(t0, 8'h07, 1'b0, 8'h00, "b07");
      chk("b07_busy_drop", {31'd0, busy}, 32'd0);
      tick();

      // Fill/overflow with random bytes: six writes, five accepted
      for (int i = 0; i < 6; i++) begin
         b     = 8'($urandom);
         we    = 1'b1;
         wdata = {24'd0, b};
         tick();
         if (i == 0) t0 = cyc + 2;
         if (i < 5) model_q.push_back(b);
      end
      we = 1'b0;
      chk("ovf_set", {31'd0, status[11]}, 32'd1);
      chk("ovf_count", {24'd0, status[7:0]}, DEPTH);
      chk("ovf_full", {31'd0, fifo_full}, 32'd1);
      chk("ovf_status", status, PAR_FLAG | 32'h0000_0D04);
      we = 1'b1; wdata = 32'h0000_0100;
      tick();
      we = 1'b0;
      chk("clr_ovf", {31'd0, status[11]}, 32'd0);
      chk("clr_count", {24'd0, status[7:0]}, DEPTH);
      chk("clr_full", {31'd0, fifo_full}, 32'd1);

      // Drain back-to-back; first frame end carries a push at full during the pop
      f = 0;
      while (model_q.size() > 0) begin
         b  = model_q.pop_front();
         ib = 8'($urandom);
         run_frame(t0, b, (f == 0), ib, $sformatf("q%0d", f));
         if (f == 0) begin
            model_q.push_back(ib);
            chk("pp_count", {24'd0, status[7:0]}, DEPTH);
            chk("pp_full", {31'd0, fifo_full}, 32'd1);
            chk("pp_ovf", {31'd0, status[11]}, 32'd0);
         end
         t0 = t0 + FRAME_CYC + 1;
         f++;
      end
      chk("drain_frames", f, 32'd6);
      chk("drain_busy", {31'd0, busy}, 32'd0);
      chk("drain_status", status, STAT_RST);

      // Reset during data bit 3 of a 0x00 frame with two more bytes queued
      tick();
      for (int i = 0; i < 3; i++) begin
         we    = 1'b1;
         wdata = (i == 0) ? 32'd0 : {24'd0, 8'($urandom)};
         tick();
         if (i == 0) t0 = cyc + 2;
      end
      we = 1'b0;
      while (cyc < t0 + 4 * DIV + 1) tick();
      chk("mid_pre_txd", {31'd0, txd}, 32'd0);
      chk("mid_pre_count", {24'd0, status[7:0]}, 32'd2);
      rst = 1'b1;
      tick();
      chk("mid_txd", {31'd0, txd}, 32'd1);
      chk("mid_count", {24'd0, status[7:0]}, 32'd0);
      chk("mid_status", status, STAT_RST);
      rst = 1'b0;
      high_ok = 1'b1;
      busy_ok = 1'b1;
      for (int i = 0; i < 3 * FRAME_CYC; i++) begin
         tick();
         if (txd !== 1'b1) high_ok = 1'b0;
         if (busy !== 1'b0) busy_ok = 1'b0;
      end
      chk("post_rst_line_idle", {31'd0, high_ok}, 32'd1);
      chk("post_rst_busy_low", {31'd0, busy_ok}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
